// File: rtl/sid_cfg_ctrl.sv
// Magic-byte configuration controller for one SID: key unlock, shadow staging, commit.
// Optional read-back of the shadow bytes is built when SID_CFG_READBACK_EN is defined.
module sid_cfg_ctrl #(
   parameter logic               DEFAULT_MODEL     = 1'b0,    // 0 = MOS6581, 1 = MOS8580
   parameter logic [2:0]         DEFAULT_ADDR      = 3'b000,  // 000 = D420, one-hot selects alternates
   parameter logic [8:0]         DEFAULT_FC_BASE   = 9'd220,
   parameter logic signed [10:0] DEFAULT_FC_OFFSET = 11'sd0,
   parameter int unsigned        TIMEOUT           = 1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_we_i,
   input  logic        bus_oe_i,
   input  logic        bus_res_i,
   input  logic [4:0]  bus_addr_i,
   input  logic [7:0]  bus_data_i,
   output logic        cfg_model_o,
   output logic [2:0]  cfg_addr_o,
   output logic [8:0]  cfg_fc_base_o,
   output logic [10:0] cfg_fc_offset_o,
   output logic        cfg_upd,
   output logic        unlocked,
   output logic [7:0]  data_o,
   output logic        data_oe,
   output logic [1:0]  state_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LD = TW'(TIMEOUT);

   typedef enum logic [1:0] {ST_LOCKED, ST_KEY1, ST_KEY2, ST_UNLOCKED} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          sh_model_q, sh_model_d;
   logic [2:0]    sh_addr_q, sh_addr_d;
   logic [8:0]    sh_base_q, sh_base_d;
   logic [10:0]   sh_off_q, sh_off_d;
   logic          cfg_model_q, cfg_model_d;
   logic [2:0]    cfg_addr_q, cfg_addr_d;
   logic [8:0]    cfg_base_q, cfg_base_d;
   logic [10:0]   cfg_off_q, cfg_off_d;
   logic          upd_q, upd_d;
   logic          unlocked_q, unlocked_d;
   logic          magic_wr, key_wr, accepted;

   assign magic_wr = bus_we_i && (bus_addr_i >= 5'h19);
   assign key_wr   = bus_we_i && (bus_addr_i == 5'h1F);
   // Only key writes count in KEY1/KEY2; any magic byte counts when unlocked.
   assign accepted = (state_q == ST_UNLOCKED) ? magic_wr :
                     (state_q == ST_LOCKED)   ? 1'b0 : key_wr;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      sh_model_d  = sh_model_q;
      sh_addr_d   = sh_addr_q;
      sh_base_d   = sh_base_q;
      sh_off_d    = sh_off_q;
      cfg_model_d = cfg_model_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_base_d  = cfg_base_q;
      cfg_off_d   = cfg_off_q;
      upd_d       = 1'b0;
      if (bus_res_i) begin
         state_d = ST_LOCKED;
         timer_d = '0;
      end else if (state_q == ST_LOCKED) begin
         if (key_wr && bus_data_i == 8'h52) begin
            state_d = ST_KEY1;
            timer_d = TIMER_LD;
         end
      end else if (accepted) begin
         timer_d = TIMER_LD;
         case (state_q)
            ST_KEY1, ST_KEY2: begin
               if (bus_data_i == 8'h52) begin
                  state_d = ST_KEY1;
               end else if (state_q == ST_KEY1 && bus_data_i == 8'h45) begin
                  state_d = ST_KEY2;
               end else if (state_q == ST_KEY2 && bus_data_i == 8'h44) begin
                  state_d    = ST_UNLOCKED;
                  sh_model_d = cfg_model_q;
                  sh_addr_d  = cfg_addr_q;
                  sh_base_d  = cfg_base_q;
                  sh_off_d   = cfg_off_q;
               end else begin
                  state_d = ST_LOCKED;
                  timer_d = '0;
               end
            end
            default: begin
               case (bus_addr_i)
                  5'h19: sh_model_d = bus_data_i[0];
                  5'h1A: if ((bus_data_i[2:0] & (bus_data_i[2:0] - 3'd1)) == 3'd0)
                            sh_addr_d = bus_data_i[2:0];
                  5'h1B: sh_base_d[7:0] = bus_data_i;
                  5'h1C: begin
                     sh_base_d[8]    = bus_data_i[0];
                     sh_off_d[10:8]  = bus_data_i[7:5];
                  end
                  5'h1D: sh_off_d[7:0] = bus_data_i;
                  5'h1E: begin
                     if (bus_data_i == 8'hA5) begin
                        cfg_model_d = sh_model_q;
                        cfg_addr_d  = sh_addr_q;
                        cfg_base_d  = sh_base_q;
                        cfg_off_d   = sh_off_q;
                        upd_d       = 1'b1;
                     end
                     state_d = ST_LOCKED;
                     timer_d = '0;
                  end
                  default: begin
                     state_d = (bus_data_i == 8'h52) ? ST_KEY1 : ST_LOCKED;
                     timer_d = (bus_data_i == 8'h52) ? TIMER_LD : '0;
                  end
               endcase
            end
         endcase
      end else if (timer_q <= TW'(1)) begin
         state_d = ST_LOCKED;
         timer_d = '0;
      end else begin
         timer_d = timer_q - TW'(1);
      end
      unlocked_d = (state_d == ST_UNLOCKED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOCKED;
         timer_q     <= '0;
         sh_model_q  <= DEFAULT_MODEL;
         sh_addr_q   <= DEFAULT_ADDR;
         sh_base_q   <= DEFAULT_FC_BASE;
         sh_off_q    <= DEFAULT_FC_OFFSET;
         cfg_model_q <= DEFAULT_MODEL;
         cfg_addr_q  <= DEFAULT_ADDR;
         cfg_base_q  <= DEFAULT_FC_BASE;
         cfg_off_q   <= DEFAULT_FC_OFFSET;
         upd_q       <= 1'b0;
         unlocked_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         sh_model_q  <= sh_model_d;
         sh_addr_q   <= sh_addr_d;
         sh_base_q   <= sh_base_d;
         sh_off_q    <= sh_off_d;
         cfg_model_q <= cfg_model_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_base_q  <= cfg_base_d;
         cfg_off_q   <= cfg_off_d;
         upd_q       <= upd_d;
         unlocked_q  <= unlocked_d;
      end
   end

`ifdef SID_CFG_READBACK_EN
   logic [7:0] rd_q, rd_d;
   logic       rd_oe_q, rd_oe_d;

   // Read-back reflects the shadow as it stood before any same-cycle write.
   always_comb begin
      rd_d    = 8'h00;
      rd_oe_d = 1'b0;
      if (bus_oe_i && !bus_res_i && state_q == ST_UNLOCKED &&
          bus_addr_i >= 5'h19 && bus_addr_i <= 5'h1D) begin
         rd_oe_d = 1'b1;
         case (bus_addr_i)
            5'h19:   rd_d = {7'd0, sh_model_q};
            5'h1A:   rd_d = {5'd0, sh_addr_q};
            5'h1B:   rd_d = sh_base_q[7:0];
            5'h1C:   rd_d = {sh_off_q[10:8], 4'd0, sh_base_q[8]};
            default: rd_d = sh_off_q[7:0];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q    <= 8'h00;
         rd_oe_q <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         rd_oe_q <= rd_oe_d;
      end
   end

   assign data_o  = rd_q;
   assign data_oe = rd_oe_q;
`else
   logic unused_oe;
   assign unused_oe = bus_oe_i;
   assign data_o    = 8'h00;
   assign data_oe   = 1'b0;
`endif

   assign cfg_model_o     = cfg_model_q;
   assign cfg_addr_o      = cfg_addr_q;
   assign cfg_fc_base_o   = cfg_base_q;
   assign cfg_fc_offset_o = cfg_off_q;
   assign cfg_upd         = upd_q;
   assign unlocked        = unlocked_q;
   assign state_o         = state_q;

endmodule

// File: doc/sid_cfg_ctrl.md
# sid_cfg_ctrl

Magic-byte configuration controller for one SID instance. It watches CPU writes to the extra write-only magic register bytes at addresses 0x19–0x1F. It runs an unlock/stage/commit sequence and drives the `cfg_t` record (model, SID #2 address, filter cutoff base/offset) consumed by the core and filter. It sits beside the register file on the same decoded bus and never blocks normal register writes.

## Interface
- `DEFAULT_MODEL`, default `MOS6581`: `cfg.model` after reset.
- `DEFAULT_ADDR`, default `D420`: `cfg.addr` after reset.
- `DEFAULT_FC_BASE`, default `9'd220`: `cfg.fc_base` after reset.
- `DEFAULT_FC_OFFSET`, default `11'sd0`: `cfg.fc_offset` after reset.
- `TIMEOUT`, default `1_000_000`: idle cycles before relock, ≥1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `bus_i` in `bus_i_t`: decoded bus. `we` is a one-cycle write strobe; `oe` is a one-cycle read strobe; `res` is the SID register reset.
- `cfg` out `cfg_t`: active configuration.
- `cfg_upd` out 1: one-cycle pulse on commit.
- `unlocked` out 1: high in state UNLOCKED.
- `data_o` out 8: read-back data.
- `data_oe` out 1: read-back drive enable.

## Operation
- Writes are accepted only when `bus_i.we`=1.
- States are LOCKED, KEY1, KEY2 and UNLOCKED. Key bytes are written to 0x1F.
- LOCKED:
  - 0x52 → KEY1.
  - Any other 0x1F write stays in LOCKED.
- KEY1:
  - 0x45 → KEY2.
  - 0x52 → KEY1 (restart).
  - Other 0x1F data → LOCKED.
- KEY2:
  - 0x44 → UNLOCKED.
  - 0x52 → KEY1.
  - Other 0x1F data → LOCKED.
- On entry to UNLOCKED, the shadow is loaded from `cfg`.
- Writes to addresses outside 0x19–0x1F are ignored in all states and do not reload the timer.
- Shadow writes in UNLOCKED:
  - 0x19: `model` = `data[0]`.
  - 0x1A: `addr` = `data[2:0]`, only if the value is 0 or one-hot. Otherwise the write is ignored (the timer is still reloaded).
  - 0x1B: `fc_base[7:0]`.
  - 0x1C: `fc_base[8]` = `data[0]`; `fc_offset[10:8]` = `data[7:5]`.
  - 0x1D: `fc_offset[7:0]`.
- 0x1E in UNLOCKED:
  - 0xA5: `cfg` ← shadow, `cfg_upd` pulses, → LOCKED.
  - Any other value: abort (shadow discarded), → LOCKED.
- 0x1F in UNLOCKED: abort. Next state is KEY1 if data=0x52, else LOCKED.
- 0x19–0x1E writes in LOCKED, KEY1 or KEY2 are ignored and do not alter key progress.
- Timer:
  - Reloaded to `TIMEOUT` on entry to KEY1 and on every accepted 0x19–0x1F write while not LOCKED.
  - Decrements each cycle while not LOCKED.
  - Reaching 0 with no write in that cycle → LOCKED, abort.
- `bus_i.res`=1 → LOCKED and shadow discarded. `cfg` is retained; only `rst_n` restores the defaults.

## Timing
- Reset values:
  - `cfg` = {`DEFAULT_MODEL`, `DEFAULT_ADDR`, `DEFAULT_FC_BASE`, `DEFAULT_FC_OFFSET`}.
  - `cfg_upd`=0, `unlocked`=0, `data_o`=0, `data_oe`=0.
  - State LOCKED; timer 0.
- All outputs are registered.
- A write strobe at cycle N takes effect in state/`cfg` at N+1. `cfg_upd` is high at N+1 only.
- Priority: `rst_n` > `bus_i.res` > write > timeout. A write in the expiry cycle is accepted and reloads the timer.
- Back-to-back writes on consecutive cycles are all processed; no throughput limit.
- `oe` and `we` in the same cycle: the write is processed; read-back returns the pre-write shadow.

## Configuration
- `SID_CFG_READBACK_EN` defined:
  - In UNLOCKED, an `oe` read of 0x19–0x1D sets `data_oe`=1 and `data_o`=shadow byte at N+1, for one cycle. Unused bits read 0.
  - Reads do not reload the timer.
- Undefined: `data_o` and `data_oe` are tied to 0 and no read decode logic is built.

## Test plan
- Reset, then write 0x1F ← 52,45,44; 0x19 ← 01; 0x1B ← 34; 0x1C ← A1; 0x1D ← 10; 0x1E ← A5 → `cfg`={MOS8580, D420, 9'h134, 11'sh510}; `cfg_upd` one cycle; `unlocked`=0.
- Write 0x1F ← 52,45,45 and then 0x19 ← 01 → stays LOCKED and `cfg` unchanged. Then 52,52,45,44 → `unlocked`=1.
- Unlock, write 0x1A ← 03 (not one-hot), then 0x1A ← 04, commit → `cfg.addr`=DE00.
- `TIMEOUT`=8: unlock, idle 8 cycles → `unlocked`=0. A commit afterwards has no effect. A write landing exactly in the expiry cycle keeps the block unlocked.
- Unlock and stage model=1, then assert `bus_i.res` in the same cycle as 0x1E ← A5 → LOCKED, `cfg` unchanged, no `cfg_upd`.
- With `SID_CFG_READBACK_EN`: unlock, write 0x1B ← 5A, read 0x1B → `data_oe`=1, `data_o`=5A at N+1. Without the macro, `data_oe` stays 0.
